// File: rtl/ece496_pkg.sv
// Shared definitions for the stream packetizer: state encoding, framing defaults
// and the header byte layout.
package ece496_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HEADER   = 3'd1,
    S_FETCH    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_SEND     = 3'd4,
    S_CHECKSUM = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam logic [3:0] DEF_HEADER_TAG = 4'hA;
  localparam logic [7:0] DEF_PAD_BYTE   = 8'h00;
  localparam int         COUNT_W        = 8;
  localparam int         TIMER_W        = 16;
  localparam int         STREAM_W       = 3;

  // Header byte: {tag nibble, reserved zero bit, stream index}
  function automatic logic [7:0] make_header(input logic [3:0] tag,
                                             input logic [STREAM_W-1:0] id);
    return {tag, 1'b0, id};
  endfunction

endpackage

// File: rtl/counter_nbit_enable_async.sv
// Generic up-counter with asynchronous active-low reset, synchronous clear
// (priority) and count enable.
module counter_nbit_enable_async #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/stream_packetizer_ece496.sv
// Packet transmit sequencer: drains PAYLOAD_BYTES from the granted stream FIFO and
// sends header + payload + XOR checksum to the UART over valid/ready.
module stream_packetizer_ece496
  import ece496_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 16,
  parameter int         STALL_LIMIT   = 1024,
  parameter logic [3:0] HEADER_TAG    = DEF_HEADER_TAG,
  parameter logic [7:0] PAD_BYTE      = DEF_PAD_BYTE
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                select_ready,
  input  logic [STREAM_W-1:0] mux_select,
  input  logic                fifo_empty,
  input  logic [7:0]          fifo_q,
  output logic                fifo_rd,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                ready_to_send,
  output logic                packet_sent
);

  localparam logic [COUNT_W-1:0] LP_PAYLOAD    = COUNT_W'(PAYLOAD_BYTES);
  localparam logic [TIMER_W-1:0] LP_STALL_LAST = TIMER_W'(STALL_LIMIT - 1);

  state_e              r_state;
  state_e              w_next;
  logic [7:0]          r_byte;
  logic [7:0]          r_csum;
  logic [STREAM_W-1:0] r_stream;
  logic                r_armed;
  logic                r_rts;
  logic [COUNT_W-1:0]  w_count;
  logic [TIMER_W-1:0]  w_timer;
  logic                w_start;
  logic                w_timeout;
  logic                w_payload_done;
  logic                w_tmr_clr;
  logic [7:0]          w_header;

  assign w_header       = make_header(HEADER_TAG, mux_select);
  assign w_start        = (r_state == S_IDLE) && select_ready && r_armed;
  assign w_timeout      = (r_state == S_FETCH) && fifo_empty && (w_timer == LP_STALL_LAST);
  assign w_payload_done = (w_count >= LP_PAYLOAD);
  assign w_tmr_clr      = (r_state != S_FETCH) || !fifo_empty || w_timeout;

  counter_nbit_enable_async #(.WIDTH(COUNT_W)) u_byte_count (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_clr   (w_start),
    .i_en    ((r_state == S_CAPTURE) || w_timeout),
    .o_count (w_count)
  );

  counter_nbit_enable_async #(.WIDTH(TIMER_W)) u_stall_timer (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_clr   (w_tmr_clr),
    .i_en    (!w_tmr_clr),
    .o_count (w_timer)
  );

  // State register and ready_to_send (held low for the first cycle after reset)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_rts   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rts   <= (w_next == S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_HEADER; else w_next = S_IDLE;
      S_HEADER:   if (tx_ready) w_next = S_FETCH; else w_next = S_HEADER;
      S_FETCH: begin
        if (!fifo_empty)    w_next = S_CAPTURE;
        else if (w_timeout) w_next = S_SEND;
        else                w_next = S_FETCH;
      end
      S_CAPTURE:  w_next = S_SEND;
      S_SEND: begin
        if (!tx_ready)           w_next = S_SEND;
        else if (w_payload_done) w_next = S_CHECKSUM;
        else                     w_next = S_FETCH;
      end
      S_CHECKSUM: if (tx_ready) w_next = S_DONE; else w_next = S_CHECKSUM;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath: outgoing byte, running checksum, latched stream and re-arm flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_byte   <= 8'h00;
      r_csum   <= 8'h00;
      r_stream <= {STREAM_W{1'b0}};
      r_armed  <= 1'b1;
    end else begin
      if (!select_ready) r_armed <= 1'b1;
      else if (w_start)  r_armed <= 1'b0;
      else               r_armed <= r_armed;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_stream <= mux_select;
            r_byte   <= w_header;
            r_csum   <= w_header;
          end
        end
        // Header is rebuilt from the latched index so later mux_select changes cannot leak in
        S_HEADER: r_byte <= make_header(HEADER_TAG, r_stream);
        S_FETCH: begin
          if (w_timeout) begin
            r_byte <= PAD_BYTE;
            r_csum <= r_csum ^ PAD_BYTE;
          end
        end
        S_CAPTURE: begin
          r_byte <= fifo_q;
          r_csum <= r_csum ^ fifo_q;
        end
        S_SEND: begin
          if (tx_ready && w_payload_done) r_byte <= r_csum;
        end
        default: r_byte <= r_byte;
      endcase
    end
  end

  assign fifo_rd       = (r_state == S_FETCH) && !fifo_empty;
  assign tx_valid      = (r_state == S_HEADER) || (r_state == S_SEND) || (r_state == S_CHECKSUM);
  assign tx_data       = r_byte;
  assign packet_sent   = (r_state == S_DONE);
  assign ready_to_send = r_rts;

endmodule
